// File: rtl/seg7_timer_pkg.sv
// Shared BCD digit type, segment codes and decoder for the
// multiplexed seven-segment timer.
package seg7_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_ZERO  = 7'b0111111;
  localparam logic [6:0] SEG_ONE   = 7'b0000110;
  localparam logic [6:0] SEG_TWO   = 7'b1011011;
  localparam logic [6:0] SEG_THREE = 7'b1001111;
  localparam logic [6:0] SEG_FOUR  = 7'b1100110;
  localparam logic [6:0] SEG_FIVE  = 7'b1101101;
  localparam logic [6:0] SEG_SIX   = 7'b1111101;
  localparam logic [6:0] SEG_SEVEN = 7'b0000111;
  localparam logic [6:0] SEG_EIGHT = 7'b1111111;
  localparam logic [6:0] SEG_NINE  = 7'b1101111;

  function automatic logic [6:0] seg7_decode(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = SEG_ONE;
      4'd2:    s = SEG_TWO;
      4'd3:    s = SEG_THREE;
      4'd4:    s = SEG_FOUR;
      4'd5:    s = SEG_FIVE;
      4'd6:    s = SEG_SIX;
      4'd7:    s = SEG_SEVEN;
      4'd8:    s = SEG_EIGHT;
      4'd9:    s = SEG_NINE;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: up/down step with carry/borrow chain,
// clamped parallel load and synchronous clear.
module bcd_digit_cell
  import seg7_timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  input  logic step_i,
  input  logic dir_down_i,
  input  logic cin_i,
  output logic cout_o,
  output bcd_t q_o
);

  bcd_t d_q, d_d;
  logic at_end;

  assign at_end = dir_down_i ? (d_q == 4'd0)
                             : (d_q == BCD_MAX);
  assign cout_o = cin_i & at_end;
  assign q_o    = d_q;

  always_comb begin
    d_d = d_q;
    if (clear_i) begin
      d_d = '0;
    end else if (load_i) begin
      d_d = (load_val_i > BCD_MAX) ? BCD_MAX
                                   : load_val_i;
    end else if (step_i && cin_i) begin
      if (dir_down_i)
        d_d = at_end ? BCD_MAX : d_q - 4'd1;
      else
        d_d = at_end ? 4'd0 : d_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   d_q <= '0;
    else if (en_i) d_q <= d_d;
  end

endmodule

// File: rtl/seg7_mux_timer.sv
// Multi-digit BCD timer with multiplexed 7-seg scan output.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_mux_timer
  import seg7_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10_000_000,
  parameter int SCAN_DIV   = 10_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    dir_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [NUM_DIGITS:0]     cy;
  logic [4*NUM_DIGITS-1:0] cnt;
  bcd_t                    cur;

  assign tick  = run && (presc_q == PW'(TICK_DIV - 1));
  assign cy[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_cell u_dig (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (ena),
      .clear_i    (clear),
      .load_i     (load),
      .load_val_i (load_value[4*i +: 4]),
      .step_i     (tick),
      .dir_down_i (dir_down),
      .cin_i      (cy[i]),
      .cout_o     (cy[i+1]),
      .q_o        (cnt[4*i +: 4])
    );
  end

  always_comb begin
    presc_d = presc_q;
    if (clear)    presc_d = '0;
    else if (run) presc_d = tick ? '0 : presc_q + 1'b1;
  end

  assign wrap_d = tick & ~clear & ~load & cy[NUM_DIGITS];

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(NUM_DIGITS - 1))
             ? '0 : idx_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // hz[i]: digit i and every digit above it are zero
  logic [NUM_DIGITS-1:0] hz;
  always_comb begin
    hz = '0;
    hz[NUM_DIGITS-1] = (cnt[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      hz[i] = hz[i+1] && (cnt[4*i +: 4] == 4'd0);
  end
`endif

  always_comb begin
    cur   = cnt[4*idx_d +: 4];
    seg_d = seg7_decode(cur);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_d != '0) && hz[idx_d]) seg_d = '0;
`endif
    sel_d = NUM_DIGITS'(1) << idx_d;
    dp_d  = (NUM_DIGITS >= 3) && (int'(idx_d) == 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= NUM_DIGITS'(1);
      seg_q   <= SEG_ZERO;
      dp_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bcd_value = cnt;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dig_sel   = sel_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_mux_timer.sv
// Directed bench for seg7_mux_timer (4 digits, tick/4, scan/2).
// Build with LEADING_ZERO_BLANK_EN to match a blanking DUT.
module tb_seg7_mux_timer;

  logic        clk = 1'b0;
  logic        rst_n, ena, run, clear, dir_down, load;
  logic [15:0] load_value, bcd_value;
  logic [6:0]  seg;
  logic        dp, wrap;
  logic [3:0]  dig_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg7_mux_timer #(
    .NUM_DIGITS (4),
    .TICK_DIV   (4),
    .SCAN_DIV   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .run        (run),
    .clear      (clear),
    .dir_down   (dir_down),
    .load       (load),
    .load_value (load_value),
    .bcd_value  (bcd_value),
    .seg        (seg),
    .dp         (dp),
    .dig_sel    (dig_sel),
    .wrap       (wrap)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] exp_sel [5];
  logic [6:0] exp_seg [5];
  logic [6:0] blank;
  int n;

  initial begin
    rst_n = 0; ena = 1; run = 0; clear = 0;
    dir_down = 0; load = 0; load_value = '0;
    step(2);
    rst_n = 1;
    run   = 1;
    step(6);
    // reset in the middle of counting
    rst_n = 0;
    #1;
    chk("rst_val", bcd_value, 16'h0000);
    chk("rst_sel", dig_sel, 4'b0001);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_dp", dp, 1'b0);
    step(1);
    rst_n = 1;
    run   = 1;
    step(36);
    chk("up9", bcd_value, 16'h0009);
    step(4);
    chk("up10", bcd_value, 16'h0010);
    run = 0;

    load = 1; load_value = 16'h9998;
    step(1);
    load = 0;
    chk("ld9998", bcd_value, 16'h9998);
    run = 1;
    step(4);
    chk("up9999", bcd_value, 16'h9999);
    chk("nowrap0", wrap, 1'b0);
    step(3);
    chk("nowrap1", wrap, 1'b0);
    step(1);
    chk("wrapval", bcd_value, 16'h0000);
    chk("wrap_hi", wrap, 1'b1);
    step(1);
    chk("wrap_lo", wrap, 1'b0);
    run = 0;
    clear = 1;
    step(1);
    clear = 0;
    chk("clear", bcd_value, 16'h0000);

    dir_down = 1; run = 1;
    step(4);
    chk("dn9999", bcd_value, 16'h9999);
    chk("dnwrap", wrap, 1'b1);
    run = 0;
    step(1);
    chk("dnwrap_lo", wrap, 1'b0);
    load = 1; load_value = 16'h1A3F;
    step(1);
    load = 0;
    chk("clamp", bcd_value, 16'h1939);

    run = 1;
    step(3);
    clear = 1; load = 1; load_value = 16'h1234;
    step(1);
    clear = 0; load = 0;
    chk("clr_ld", bcd_value, 16'h0000);
    chk("clr_nowrap", wrap, 1'b0);
    step(2);
    run = 0;
    step(20);
    chk("hold", bcd_value, 16'h0000);
    run = 1;
    step(1);
    chk("presc3", bcd_value, 16'h0000);
    step(1);
    chk("presc_tick", bcd_value, 16'h9999);
    run = 0; dir_down = 0;

    load = 1; load_value = 16'h0042;
    step(1);
    load = 0;
    ena = 0; run = 1;
    step(8);
    chk("ena_hold", bcd_value, 16'h0042);
    ena = 1; run = 0;

`ifdef LEADING_ZERO_BLANK_EN
    blank = 7'h00;
`else
    blank = 7'h3F;
`endif
    exp_sel = '{4'b0001, 4'b0010, 4'b0100,
                4'b1000, 4'b0001};
    exp_seg = '{7'h5B, 7'h66, blank, blank, 7'h5B};

    n = 0;
    while (dig_sel !== 4'b1000 && n < 16) begin
      step(1);
      n++;
    end
    chk("sync_hi", dig_sel, 4'b1000);
    n = 0;
    while (dig_sel === 4'b1000 && n < 4) begin
      step(1);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sel%0d", k), dig_sel, exp_sel[k]);
      chk($sformatf("dp%0d", k), dp, exp_sel[k] == 4'b0100);
      chk($sformatf("seg%0d", k), seg, exp_seg[k]);
      step(1);
      chk($sformatf("selh%0d", k), dig_sel, exp_sel[k]);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
